// File: rtl/dsp_mac_pipe.sv
// dsp_mac_pipe: 3-stage signed multiply-accumulate over first/last delimited groups, valid/ready both sides.
// Optional DSP_MAC_SAT_EN: saturate the accumulator on signed overflow instead of wrapping.
module dsp_mac_pipe #(
   parameter int N     = 8,
   parameter int ACC_W = 2*N+8
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    in_valid_i,
   output logic                    in_ready_o,
   input  logic signed [N-1:0]     x_i,
   input  logic signed [N-1:0]     y_i,
   input  logic                    in_first_i,
   input  logic                    in_last_i,
   output logic                    out_valid_o,
   input  logic                    out_ready_i,
   output logic signed [ACC_W-1:0] r_o,
   output logic                    ovf_o
);

   logic                    stall;
   logic [2:1]              vld_pipe_q;
   logic signed [N-1:0]     s1_x_q, s1_y_q;
   logic                    s1_first_q, s1_last_q;
   logic signed [2*N-1:0]   p_d, s2_p_q;
   logic                    s2_first_q, s2_last_q;
   logic signed [ACC_W-1:0] acc_q, acc_d, p_ext, sum;
   logic                    sticky_q, sticky_d, add_ovf;
   logic                    out_vld_q, out_vld_d, ovf_q, ovf_d;
   logic signed [ACC_W-1:0] r_q, r_d;

`ifdef DSP_MAC_SAT_EN
   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

   assign stall      = out_vld_q & ~out_ready_i;
   assign in_ready_o = ~stall & ~rst_i;

   // Operands are sign-extended first so the low 2N bits hold the exact product,
   // including (-2^(N-1))^2.
   assign p_d = $signed({{N{s1_x_q[N-1]}}, s1_x_q}) * $signed({{N{s1_y_q[N-1]}}, s1_y_q});

   always_comb begin
      p_ext     = ACC_W'(s2_p_q);
      sum       = acc_q + p_ext;
      add_ovf   = (acc_q[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);
      acc_d     = acc_q;
      sticky_d  = sticky_q;
      out_vld_d = out_vld_q;
      r_d       = r_q;
      ovf_d     = ovf_q;
      if (vld_pipe_q[2]) begin
         if (s2_first_q) begin
            acc_d    = p_ext;
            sticky_d = 1'b0;
         end else begin
            sticky_d = sticky_q | add_ovf;
`ifdef DSP_MAC_SAT_EN
            if (add_ovf) acc_d = acc_q[ACC_W-1] ? ACC_MIN : ACC_MAX;
            else         acc_d = sum;
`else
            acc_d = sum;
`endif
         end
      end
      if (vld_pipe_q[2] && s2_last_q) begin
         out_vld_d = 1'b1;
         r_d       = acc_d;
         ovf_d     = sticky_d;
      end else if (out_ready_i) begin
         out_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         vld_pipe_q <= '0;
         s1_x_q     <= '0;
         s1_y_q     <= '0;
         s1_first_q <= 1'b0;
         s1_last_q  <= 1'b0;
         s2_p_q     <= '0;
         s2_first_q <= 1'b0;
         s2_last_q  <= 1'b0;
         acc_q      <= '0;
         sticky_q   <= 1'b0;
         out_vld_q  <= 1'b0;
         r_q        <= '0;
         ovf_q      <= 1'b0;
      end else if (!stall) begin
         vld_pipe_q <= {vld_pipe_q[1], in_valid_i};
         s1_x_q     <= x_i;
         s1_y_q     <= y_i;
         s1_first_q <= in_first_i;
         s1_last_q  <= in_last_i;
         s2_p_q     <= p_d;
         s2_first_q <= s1_first_q;
         s2_last_q  <= s1_last_q;
         acc_q      <= acc_d;
         sticky_q   <= sticky_d;
         out_vld_q  <= out_vld_d;
         r_q        <= r_d;
         ovf_q      <= ovf_d;
      end
   end

   assign out_valid_o = out_vld_q;
   assign r_o         = r_q;
   assign ovf_o       = ovf_q;

endmodule

// File: doc/dsp_mac_pipe.md
Name: dsp_mac_pipe

Overview:
- Parametrised successor to the team's single-cycle signed N×N DSP multiply block.
- Adds input and product registers plus a signed accumulator, and processes groups of operands delimited by first/last flags.
- Uses valid/ready handshakes on both sides with full-pipeline backpressure.
- Sits between operand sourcing logic and the posit/quire accumulation path in the MAC datapath.

Parameters:
- N, 8, signed operand width of x and y.
- ACC_W, 2*N+8, accumulator and result width; must be >= 2*N.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  block can accept a beat this cycle.
- x  in  N  signed operand.
- y  in  N  signed operand.
- in_first  in  1  beat starts a new accumulation group.
- in_last  in  1  beat ends the group; the result is emitted after it.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- r  out  ACC_W  signed group sum.
- ovf  out  1  overflow occurred within the reported group (sticky per group).

Behaviour:
- Reset (rst=1 at a clk edge): all stage valids=0, out_valid=0, r=0, ovf=0, accumulator=0.
  - Reset mid-group discards the partial sum and all in-flight beats.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational) and is held 0 during rst.
  - A beat is accepted when in_valid & in_ready.
  - When stall=1 every pipeline register and the accumulator hold their values.
- Pipeline, advancing when stall=0:
  - S1: register x, y, first, last and valid.
  - S2: signed product p = x*y, full 2N bits, registered with its flags.
  - S3: accumulate.
    - If S2.first, acc <= sext(p).
    - Else acc <= acc + sext(p), computed in ACC_W bits.
- Latency:
  - The result for a beat with last=1 appears on r with out_valid=1 exactly 3 cycles after acceptance, absent stalls.
  - Throughput is one beat per cycle.
- Output register:
  - When the S3 beat has last=1, r <= new acc value and out_valid <= 1, with ovf set per the rule below.
  - If out_valid & out_ready and no new result arrives, out_valid <= 0.
  - If out_valid & out_ready and a new result arrives in the same cycle, r is replaced and out_valid stays 1.
  - r and ovf are stable while out_valid & ~out_ready.
- Group rules:
  - first & last on the same beat: r = sext(x*y).
  - A beat with first=0 following a completed group continues from the previous acc value. Streams are expected to assert first; this is not checked.
  - Bubbles (in_valid=0) do not change acc.
- Overflow:
  - Signed overflow of any S3 addition sets the group's sticky flag; first clears it.
  - ovf reports the flag at emission.
  - The product itself never overflows because its 2N bits fit in ACC_W.
- Corner: x=y=-2^(N-1) gives p=+2^(2N-2), which must be represented correctly.

Optional Feature:
- Macro: DSP_MAC_SAT_EN
- Defined:
  - On signed overflow, acc saturates to +2^(ACC_W-1)-1 or -2^(ACC_W-1), according to the operand signs.
  - Subsequent adds in the group continue from the saturated value.
  - ovf behaves as above.
- Undefined: two's-complement wrap-around; ovf still reported.

Test Plan (N=8, ACC_W=24):
- Single beat x=-128, y=-128, first=last=1, out_ready=1 -> 3 cycles later r=16384, out_valid=1 for one cycle, ovf=0.
- Group of 4 back-to-back beats: (3,4), (-5,6), (127,127), (-1,-1) -> r=12-30+16129+1=16112; out_valid asserted only after the 4th beat; in_ready stays 1.
- Backpressure: stream 2 single-beat groups (2,3) then (-7,9) with out_ready=0 -> r=6 held, in_ready=0, and the second result is not lost. Raise out_ready -> r=6 accepted, then r=-63.
- Overflow: group of 512 beats of (-128,-128), sum 8388608 -> without the macro r=-8388608, ovf=1; with DSP_MAC_SAT_EN r=8388607, ovf=1. Next group (1,1) single -> r=1, ovf=0.
- Reset mid-group: 2 beats (10,10) accepted, then rst for 1 cycle, then single (2,2) with first=last=1 -> out_valid=0 immediately after reset, then r=4.
- Bubbles: group (1,1), idle 3 cycles, (2,2) last -> r=5; out_valid rises 3 cycles after the last beat.
